// File: rtl/player_y_ctl.sv
`default_nettype none
// ============================================================================
// Module   : player_y_ctl
// Brief    : Per-player vertical motion: jump, gravity, floor/ceiling and
//            riding the moving platform. Advances once per v_tick rising edge.
//            Optional double jump enabled by defining PLAYER_DOUBLE_JUMP_EN.
// Revision : 1.0
// ============================================================================
module player_y_ctl #(
    parameter int GROUND_Y = 540,
    parameter int RECT_W   = 128,
    parameter int PLAYER_W = 48,
    parameter int JUMP_V0  = 10,
    parameter int GRAVITY  = 1,
    parameter int V_MAX    = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        v_tick,
    input  logic        jump,
    input  logic [11:0] xpos_player,
    input  logic [11:0] xpos_rect,
    input  logic [11:0] ypos_rect,
    output logic [11:0] ypos_player,
    output logic        on_platform
);

    localparam logic [1:0] c_ST_GROUND  = 2'd0;
    localparam logic [1:0] c_ST_ON_RECT = 2'd1;
    localparam logic [1:0] c_ST_AIR     = 2'd2;

    localparam logic [11:0]       c_GROUND_Y   = 12'(GROUND_Y);
    localparam logic [11:0]       c_JUMP_V0    = 12'(JUMP_V0);
    localparam logic [12:0]       c_RECT_W     = 13'(RECT_W);
    localparam logic [12:0]       c_PLAYER_W   = 13'(PLAYER_W);
    localparam logic signed [7:0] c_VEL_LAUNCH = 8'(GRAVITY - JUMP_V0);
    localparam logic signed [8:0] c_GRAVITY    = 9'(GRAVITY);
    localparam logic signed [8:0] c_V_MAX      = 9'(V_MAX);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [11:0]       r_y;
    logic [11:0]       w_y_nxt;
    logic signed [7:0] r_vel;
    logic signed [7:0] w_vel_nxt;
    logic              r_v_tick_old;
    logic              r_jump_prev;

    logic              w_tick;
    logic              w_jump_edge;
    logic              w_overlap;
    logic signed [13:0] w_y_fall;
    logic signed [8:0] w_vel_inc;
    logic signed [7:0] w_vel_fall;
    logic [11:0]       w_launch_base;
    logic [11:0]       w_launch_y;
    logic              w_land_rect;
    logic              w_land_floor;
    logic              w_hit_ceiling;
    logic              w_dj_use;

    assign w_tick      = v_tick && !r_v_tick_old;
    assign w_jump_edge = jump && !r_jump_prev;

    assign w_overlap = (({1'b0, xpos_player} + c_PLAYER_W) > {1'b0, xpos_rect}) &&
                       ({1'b0, xpos_player} < ({1'b0, xpos_rect} + c_RECT_W));

    // Free-fall step, widened so that both floor overshoot and ceiling underflow are visible
    assign w_y_fall   = $signed({2'b00, r_y}) + $signed({{6{r_vel[7]}}, r_vel});
    assign w_vel_inc  = $signed({r_vel[7], r_vel}) + c_GRAVITY;
    assign w_vel_fall = (w_vel_inc > c_V_MAX) ? c_V_MAX[7:0] : w_vel_inc[7:0];

    assign w_land_rect   = !r_vel[7] && w_overlap && (r_y <= ypos_rect) &&
                           (w_y_fall >= $signed({2'b00, ypos_rect}));
    assign w_land_floor  = (w_y_fall >= $signed({2'b00, c_GROUND_Y}));
    assign w_hit_ceiling = w_y_fall[13];

    // Launch height is clamped at the top edge rather than wrapping
    always_comb begin
        w_launch_base = r_y;
        if (r_state == c_ST_GROUND) begin
            w_launch_base = c_GROUND_Y;
        end else if (r_state == c_ST_ON_RECT) begin
            w_launch_base = ypos_rect;
        end
        w_launch_y = (w_launch_base < c_JUMP_V0) ? 12'd0 : (w_launch_base - c_JUMP_V0);
    end

`ifdef PLAYER_DOUBLE_JUMP_EN
    logic r_dj_avail;
    assign w_dj_use = (r_state == c_ST_AIR) && w_jump_edge && r_dj_avail;
`else
    assign w_dj_use = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_y_nxt     = r_y;
        w_vel_nxt   = r_vel;
        case (r_state)
            c_ST_GROUND: begin
                if (w_jump_edge) begin
                    w_y_nxt     = w_launch_y;
                    w_vel_nxt   = c_VEL_LAUNCH;
                    w_state_nxt = c_ST_AIR;
                end else begin
                    w_y_nxt = c_GROUND_Y;
                end
            end
            c_ST_ON_RECT: begin
                if (w_jump_edge) begin
                    w_y_nxt     = w_launch_y;
                    w_vel_nxt   = c_VEL_LAUNCH;
                    w_state_nxt = c_ST_AIR;
                end else begin
                    w_y_nxt = ypos_rect;
                    if (!w_overlap) begin
                        w_vel_nxt   = 8'sd0;
                        w_state_nxt = c_ST_AIR;
                    end
                end
            end
            default: begin
                if (w_dj_use) begin
                    w_y_nxt   = w_launch_y;
                    w_vel_nxt = c_VEL_LAUNCH;
                end else if (w_land_rect) begin
                    w_y_nxt     = ypos_rect;
                    w_vel_nxt   = 8'sd0;
                    w_state_nxt = c_ST_ON_RECT;
                end else if (w_land_floor) begin
                    w_y_nxt     = c_GROUND_Y;
                    w_vel_nxt   = 8'sd0;
                    w_state_nxt = c_ST_GROUND;
                end else if (w_hit_ceiling) begin
                    w_y_nxt   = 12'd0;
                    w_vel_nxt = 8'sd0;
                end else begin
                    w_y_nxt   = w_y_fall[11:0];
                    w_vel_nxt = w_vel_fall;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v_tick_old <= 1'b0;
            r_jump_prev  <= 1'b0;
            r_state      <= c_ST_GROUND;
            r_y          <= c_GROUND_Y;
            r_vel        <= 8'sd0;
            on_platform  <= 1'b0;
        end else begin
            r_v_tick_old <= v_tick;
            if (w_tick) begin
                r_jump_prev <= jump;
                r_state     <= w_state_nxt;
                r_y         <= w_y_nxt;
                r_vel       <= w_vel_nxt;
                on_platform <= (w_state_nxt == c_ST_ON_RECT);
            end
        end
    end

`ifdef PLAYER_DOUBLE_JUMP_EN
    // Re-armed whenever the player ends a frame supported by floor or platform
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dj_avail <= 1'b1;
        end else if (w_tick) begin
            if (w_state_nxt != c_ST_AIR) begin
                r_dj_avail <= 1'b1;
            end else if (w_dj_use) begin
                r_dj_avail <= 1'b0;
            end
        end
    end
`endif

    assign ypos_player = r_y;

endmodule
`default_nettype wire

// File: tb/tb_player_y_ctl.sv
`default_nettype none
// Testbench for player_y_ctl: frame-level reference model compared every cycle,
// plus directed scenarios with hand-computed positions.
module tb_player_y_ctl;

    localparam int GY = 540;
    localparam int RW = 128;
    localparam int PW = 48;
    localparam int JV = 10;
    localparam int GR = 1;
    localparam int VM = 15;
`ifdef PLAYER_DOUBLE_JUMP_EN
    localparam bit DJ = 1'b1;
`else
    localparam bit DJ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v_tick = 1'b0;
    logic        jump = 1'b0;
    logic [11:0] xpos_player = 12'd0;
    logic [11:0] xpos_rect = 12'd476;
    logic [11:0] ypos_rect = 12'd500;
    logic [11:0] ypos_player;
    logic        on_platform;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    player_y_ctl dut (
        .clk         (clk),
        .rst         (rst),
        .v_tick      (v_tick),
        .jump        (jump),
        .xpos_player (xpos_player),
        .xpos_rect   (xpos_rect),
        .ypos_rect   (ypos_rect),
        .ypos_player (ypos_player),
        .on_platform (on_platform)
    );

    // Reference model: where the player is (y), how fast (vel), and what supports it
    int m_y = GY;
    int m_vel = 0;
    bit m_air = 1'b0;
    bit m_ride = 1'b0;
    bit m_jp = 1'b0;
    bit m_vold = 1'b0;
    bit m_dj = 1'b1;

    task automatic launch(input int base);
        m_y    = (base - JV < 0) ? 0 : base - JV;
        m_vel  = GR - JV;
        m_air  = 1'b1;
        m_ride = 1'b0;
    endtask

    task automatic frame_step();
        bit edge_j;
        bit ov;
        int yn;
        int vn;
        int yr;
        edge_j = jump && !m_jp;
        m_jp   = jump;
        yr     = int'(ypos_rect);
        ov = (int'(xpos_player) + PW > int'(xpos_rect)) &&
             (int'(xpos_player) < int'(xpos_rect) + RW);
        if (m_ride) begin
            if (edge_j) launch(yr);
            else begin
                m_y = yr;
                if (!ov) begin
                    m_vel = 0; m_ride = 1'b0; m_air = 1'b1;
                end
            end
        end else if (!m_air) begin
            if (edge_j) launch(GY);
            else m_y = GY;
        end else if (DJ && edge_j && m_dj) begin
            launch(m_y);
            m_dj = 1'b0;
        end else begin
            yn = m_y + m_vel;
            vn = (m_vel + GR > VM) ? VM : m_vel + GR;
            if (m_vel >= 0 && ov && m_y <= yr && yn >= yr) begin
                m_y = yr; m_vel = 0; m_air = 1'b0; m_ride = 1'b1; m_dj = 1'b1;
            end else if (yn >= GY) begin
                m_y = GY; m_vel = 0; m_air = 1'b0; m_dj = 1'b1;
            end else if (yn < 0) begin
                m_y = 0; m_vel = 0;
            end else begin
                m_y = yn; m_vel = vn;
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_y = GY; m_vel = 0; m_air = 1'b0; m_ride = 1'b0;
            m_jp = 1'b0; m_vold = 1'b0; m_dj = 1'b1;
        end else begin
            if (v_tick && !m_vold) frame_step();
            m_vold = v_tick;
        end
        cmp_en <= 1'b1;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (int'(ypos_player) != m_y || on_platform !== m_ride) begin
                errors++;
                $display("FAIL model t=%0t: ypos_player=%0d on_platform=%0b, required %0d %0b",
                         $time, ypos_player, on_platform, m_y, m_ride);
            end
        end
    end

    task automatic expect_out(input string name, input int ey, input bit eon);
        checks++;
        if (int'(ypos_player) != ey || on_platform !== eon || m_y != ey || m_ride != eon) begin
            errors++;
            $display("FAIL %s: dut y=%0d on=%0b model y=%0d on=%0b, required y=%0d on=%0b",
                     name, ypos_player, on_platform, m_y, m_ride, ey, eon);
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after a rising edge
    task automatic tick(input int hold);
        v_tick = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        v_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int step;
        int yr;
        repeat (3) @(posedge clk);
        #1;
        expect_out("reset", 540, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tick(1 + i % 3);
            expect_out("idle", 540, 1'b0);
        end

        xpos_player = 12'd0; xpos_rect = 12'd476; ypos_rect = 12'd500;
        jump = 1'b1;
        tick(1);
        expect_out("jump_t1", 530, 1'b0);
        repeat (9) tick(1);
        expect_out("apex_t10", 485, 1'b0);
        repeat (11) tick(2);
        expect_out("floor_t21", 540, 1'b0);

        jump = 1'b0;
        tick(1);
        xpos_player = 12'd500;
        jump = 1'b1;
        tick(1);
        expect_out("rect_jump_t1", 530, 1'b0);
        repeat (14) tick(1);
        expect_out("rect_pre_land", 495, 1'b0);
        tick(1);
        expect_out("rect_land", 500, 1'b1);

        ypos_rect = 12'd499;
        tick(1);
        expect_out("ride_499", 499, 1'b1);
        ypos_rect = 12'd498;
        tick(1);
        expect_out("ride_498", 498, 1'b1);
        ypos_rect = 12'd500;
        tick(1);
        expect_out("ride_500", 500, 1'b1);

        xpos_player = 12'd700;
        tick(1);
        expect_out("walk_off", 500, 1'b0);
        tick(1);
        expect_out("fall_500", 500, 1'b0);
        tick(1);
        expect_out("fall_501", 501, 1'b0);
        tick(1);
        expect_out("fall_503", 503, 1'b0);
        repeat (7) tick(1);
        expect_out("fall_floor", 540, 1'b0);

        jump = 1'b0;
        tick(1);
        xpos_player = 12'd0;
        jump = 1'b1;
        tick(1);
        jump = 1'b0;
        repeat (3) tick(1);
        expect_out("dj_pre", 506, 1'b0);
        jump = 1'b1;
        tick(1);
        expect_out("dj_edge", DJ ? 496 : 500, 1'b0);
        jump = 1'b0;
        tick(1);
        jump = 1'b1;
        tick(1);
        repeat (30) tick(1);
        expect_out("dj_settle", 540, 1'b0);

        jump = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            jump = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) xpos_player = 12'($urandom_range(0, 800));
            if ($urandom_range(0, 7) == 0) xpos_rect = 12'($urandom_range(0, 700));
            if ($urandom_range(0, 15) == 0) begin
                yr = int'($urandom_range(0, 560));
            end else begin
                step = int'($urandom_range(0, 6)) - 3;
                yr = int'(ypos_rect) + step;
                if (yr < 0) yr = 0;
                if (yr > 560) yr = 560;
            end
            ypos_rect = 12'(yr);
            tick(int'($urandom_range(1, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
